// File: rtl/hazard_ctrl_pkg.sv
// Shared types and constants for the pipeline hazard/stall/flush controller.
// The load-use detection helper is kept here so other pipeline blocks can reuse it.
package hazard_ctrl_pkg;

    localparam int REG_W = 5;
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MEM_WAIT = 2'd1,
        HALT     = 2'd2
    } state_e;

    // x0 is hardwired to zero, so a load targeting it never creates a hazard.
    function automatic logic load_use_hit(
        input logic             mem_read,
        input logic [REG_W-1:0] rd,
        input logic [REG_W-1:0] rs1,
        input logic             uses_rs1,
        input logic [REG_W-1:0] rs2,
        input logic             uses_rs2
    );
        logic hit_s;
        hit_s = mem_read && (rd != {REG_W{1'b0}}) &&
                ((uses_rs1 && (rs1 == rd)) || (uses_rs2 && (rs2 == rd)));
        return hit_s;
    endfunction

endpackage

// File: rtl/hazard_ctrl_if.sv
// Bundle between the pipeline (master) and the hazard controller (slave):
// hazard observations in, stall/flush controls and status out.
interface hazard_ctrl_if #(
    parameter int CNT_W = 16
);
    import hazard_ctrl_pkg::*;

    logic [REG_W-1:0] id_rs1;
    logic [REG_W-1:0] id_rs2;
    logic             id_uses_rs1;
    logic             id_uses_rs2;
    logic [REG_W-1:0] ex_rd;
    logic             ex_mem_read;
    logic             br_taken;
    logic             lsu_req;
    logic             lsu_done;

    logic             pc_stall;
    logic             ifid_stall;
    logic             idex_stall;
    logic             exmem_stall;
    logic             ifid_flush;
    logic             idex_flush;
    logic             lsu_timeout;
    logic [CNT_W-1:0] stall_cycles;
    logic [CNT_W-1:0] flush_count;

    modport master (
        output id_rs1, id_rs2, id_uses_rs1, id_uses_rs2,
        output ex_rd, ex_mem_read, br_taken, lsu_req, lsu_done,
        input  pc_stall, ifid_stall, idex_stall, exmem_stall,
        input  ifid_flush, idex_flush, lsu_timeout, stall_cycles, flush_count
    );

    modport slave (
        input  id_rs1, id_rs2, id_uses_rs1, id_uses_rs2,
        input  ex_rd, ex_mem_read, br_taken, lsu_req, lsu_done,
        output pc_stall, ifid_stall, idex_stall, exmem_stall,
        output ifid_flush, idex_flush, lsu_timeout, stall_cycles, flush_count
    );

endinterface

// File: rtl/hazard_ctrl_sat_counter.sv
// Saturating up-counter: increments on inc, sticks at all-ones instead of wrapping.
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc,
    output logic [W-1:0] count
);
    import hazard_ctrl_pkg::*;

    logic [W-1:0] count_r;

    // Count register with synchronous clear and saturation.
    always_ff @(posedge clk) begin
        if (rst) begin
            count_r <= {W{1'b0}};
        end else if (inc && (count_r != {W{1'b1}})) begin
            count_r <= count_r + {{(W-1){1'b0}}, 1'b1};
        end else begin
            count_r <= count_r;
        end
    end

    assign count = count_r;

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: Mealy stall/flush generation for load-use, taken
// branches and multi-cycle LSU accesses, plus an LSU watchdog and perf counters.
module hazard_ctrl #(
    parameter int LSU_TIMEOUT = 16,
    parameter int CNT_W       = 16
) (
    input  logic          clk,
    input  logic          rst,
    hazard_ctrl_if.slave  bus
);
    import hazard_ctrl_pkg::*;

    localparam int WC_W = $clog2(LSU_TIMEOUT + 1);
    localparam logic [WC_W-1:0] WAIT_LAST = WC_W'(LSU_TIMEOUT - 1);
    localparam logic [WC_W-1:0] WAIT_ONE  = WC_W'(1);
    localparam logic [WC_W-1:0] WAIT_ZERO = WC_W'(0);

    state_e          state_r;
    state_e          next_state_s;
    logic [WC_W-1:0] wait_cnt_r;
    logic [WC_W-1:0] next_wait_cnt_s;
    logic            timeout_r;

    logic load_use_s;
    logic mem_stall_s;
    logic pc_stall_s;
    logic ifid_stall_s;
    logic idex_stall_s;
    logic exmem_stall_s;
    logic ifid_flush_s;
    logic idex_flush_s;

    assign load_use_s  = load_use_hit(bus.ex_mem_read, bus.ex_rd,
                                      bus.id_rs1, bus.id_uses_rs1,
                                      bus.id_rs2, bus.id_uses_rs2);
    assign mem_stall_s = bus.lsu_req && !bus.lsu_done;

    // State, wait counter and sticky watchdog flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r    <= RUN;
            wait_cnt_r <= WAIT_ZERO;
            timeout_r  <= 1'b0;
        end else begin
            state_r    <= next_state_s;
            wait_cnt_r <= next_wait_cnt_s;
            if (next_state_s == HALT) begin
                timeout_r <= 1'b1;
            end else begin
                timeout_r <= timeout_r;
            end
        end
    end

    // Next-state and Mealy control decode; reset masks every control to zero.
    always_comb begin
        next_state_s    = state_r;
        next_wait_cnt_s = wait_cnt_r;
        pc_stall_s      = 1'b0;
        ifid_stall_s    = 1'b0;
        idex_stall_s    = 1'b0;
        exmem_stall_s   = 1'b0;
        ifid_flush_s    = 1'b0;
        idex_flush_s    = 1'b0;

        case (state_r)
            RUN: begin
                if (mem_stall_s) begin
                    pc_stall_s      = 1'b1;
                    ifid_stall_s    = 1'b1;
                    idex_stall_s    = 1'b1;
                    exmem_stall_s   = 1'b1;
                    next_state_s    = MEM_WAIT;
                    next_wait_cnt_s = WAIT_ONE;
                end else if (bus.br_taken) begin
                    // The ID instruction is squashed, so a coincident load-use is moot.
                    ifid_flush_s = 1'b1;
                    idex_flush_s = 1'b1;
                end else if (load_use_s) begin
                    pc_stall_s   = 1'b1;
                    ifid_stall_s = 1'b1;
                    idex_flush_s = 1'b1;
                end else begin
                    next_state_s = RUN;
                end
            end
            MEM_WAIT: begin
                if (bus.lsu_done) begin
                    // Frozen EX/ID hazards are re-evaluated in RUN next cycle.
                    next_state_s    = RUN;
                    next_wait_cnt_s = WAIT_ZERO;
                end else begin
                    pc_stall_s    = 1'b1;
                    ifid_stall_s  = 1'b1;
                    idex_stall_s  = 1'b1;
                    exmem_stall_s = 1'b1;
                    if (wait_cnt_r == WAIT_LAST) begin
                        next_state_s = HALT;
                    end else begin
                        next_wait_cnt_s = wait_cnt_r + WAIT_ONE;
                    end
                end
            end
            HALT: begin
                pc_stall_s    = 1'b1;
                ifid_stall_s  = 1'b1;
                idex_stall_s  = 1'b1;
                exmem_stall_s = 1'b1;
            end
            default: begin
                next_state_s    = RUN;
                next_wait_cnt_s = WAIT_ZERO;
            end
        endcase

        if (rst) begin
            pc_stall_s    = 1'b0;
            ifid_stall_s  = 1'b0;
            idex_stall_s  = 1'b0;
            exmem_stall_s = 1'b0;
            ifid_flush_s  = 1'b0;
            idex_flush_s  = 1'b0;
        end else begin
            next_state_s = next_state_s;
        end
    end

    sat_counter #(.W(CNT_W)) u_stall_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (pc_stall_s),
        .count (bus.stall_cycles)
    );

    sat_counter #(.W(CNT_W)) u_flush_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (ifid_flush_s),
        .count (bus.flush_count)
    );

    assign bus.pc_stall    = pc_stall_s;
    assign bus.ifid_stall  = ifid_stall_s;
    assign bus.idex_stall  = idex_stall_s;
    assign bus.exmem_stall = exmem_stall_s;
    assign bus.ifid_flush  = ifid_flush_s;
    assign bus.idex_flush  = idex_flush_s;
    assign bus.lsu_timeout = timeout_r;

endmodule

// File: doc/hazard_ctrl.md
# hazard_ctrl

Pipeline hazard and stall/flush controller for the 5-stage core with LSU. Observes ID source registers, EX destination/load status, EX branch resolution and the MEM-stage LSU handshake. Drives the stall/flush controls of the PC, IF/ID (instruction register, which injects a NOP on flush), ID/EX and EX/MEM registers. Keeps a watchdog on outstanding LSU accesses and saturating performance counters.

## Interface
- LSU_TIMEOUT, default 16: max consecutive cycles stalled on one LSU access before HALT (≥2).
- CNT_W, default 16: width of performance counters.
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- id_rs1, id_rs2  in  5 each  source register indices of the instruction in ID.
- id_uses_rs1, id_uses_rs2  in  1 each  ID instruction actually reads rs1/rs2.
- ex_rd  in  5  destination of the instruction in EX.
- ex_mem_read  in  1  EX instruction is a load.
- br_taken  in  1  branch/jump taken, resolved in EX.
- lsu_req  in  1  MEM stage holds a valid load/store.
- lsu_done  in  1  LSU completes the MEM-stage access this cycle.
- pc_stall, ifid_stall, idex_stall, exmem_stall  out  1 each  hold respective register.
- ifid_flush, idex_flush  out  1 each  load NOP/bubble into respective register.
- lsu_timeout  out  1  sticky watchdog flag.
- stall_cycles  out  CNT_W  cycles with pc_stall=1, saturating.
- flush_count  out  CNT_W  cycles with ifid_flush=1, saturating.

## Operation
- FSM states: RUN, MEM_WAIT, HALT. Internal wait_cnt, width $clog2(LSU_TIMEOUT+1).
- load_use = ex_mem_read && ex_rd != 0 && ((id_uses_rs1 && id_rs1 == ex_rd) || (id_uses_rs2 && id_rs2 == ex_rd)).
- mem_stall = lsu_req && !lsu_done.
- Control outputs are Mealy (state + inputs). Priority in RUN: mem_stall > br_taken > load_use.
  - mem_stall: all four stalls = 1, both flushes = 0; next MEM_WAIT, wait_cnt ← 1.
  - br_taken: ifid_flush = idex_flush = 1, stalls 0. Load-use in the same cycle is ignored (ID instruction is squashed).
  - load_use: pc_stall = ifid_stall = 1, idex_flush = 1; others 0. One bubble; hazard clears as the bubble enters EX.
  - otherwise all controls 0.
- MEM_WAIT:
  - lsu_done=1: all controls 0 this cycle (pipeline advances); next RUN. br_taken/load_use are not evaluated in this cycle; they persist and are handled in RUN next cycle since EX/ID were frozen.
  - lsu_done=0: all four stalls = 1. If wait_cnt == LSU_TIMEOUT-1 → HALT, else wait_cnt++.
- HALT: all four stalls = 1, flushes 0, lsu_timeout = 1; exit only via rst. lsu_done ignored.
- Counters: +1 per cycle where the respective output is 1, saturate at all-ones, no wrap.

## Timing
- rst=1 at a rising edge: state ← RUN, wait_cnt ← 0, lsu_timeout ← 0, both counters ← 0. While rst=1, all stall/flush outputs forced 0. Reset mid-MEM_WAIT or in HALT behaves identically.
- Control outputs have zero latency (combinational) from inputs. lsu_timeout is registered: rises the cycle after the HALT transition edge.
- The LSU stall lasts exactly until the lsu_done cycle; a single-cycle access (lsu_req && lsu_done) produces no stall.
- Counters update on the edge after the counted cycle.
- HALT is entered after exactly LSU_TIMEOUT consecutive stalled cycles without lsu_done.

## Structure
- Package hazard_ctrl_pkg: state enum (RUN, MEM_WAIT, HALT), REG_W = 5, NOP_INSTR = 32'h0000_0013 (addi x0,x0,0) shared with the IF/ID register.
- One sub-module: sat_counter (parameter W; inputs clk, rst, inc; output count), instantiated twice.

## Test plan
- Load-use: ex_mem_read=1, ex_rd=5, id_rs2=5, id_uses_rs2=1 -> pc_stall=ifid_stall=idex_flush=1 for one cycle; with ex_rd=0 -> no stall.
- Branch plus load-use same cycle -> ifid_flush=idex_flush=1, pc_stall=0; flush_count increments by 1.
- LSU held 3 cycles (lsu_req=1, lsu_done at cycle 3) -> all stalls high cycles 0–2, low at cycle 3, state back to RUN; stall_cycles += 3.
- Branch pending during MEM_WAIT -> no flush until after the lsu_done cycle, flush in the following RUN cycle.
- LSU_TIMEOUT=16, lsu_done never -> HALT after 16 stalled cycles, lsu_timeout=1 on next cycle, stays stalled; rst for 1 cycle -> RUN, counters and flag 0.
- Counter saturation with CNT_W=4: 20 stalled cycles -> stall_cycles = 15, no wrap.
